// File: rtl/ahb_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_pkg
//   Shared AHB-Lite bus types plus the definitions used by the SRAM
//   subordinate:
//     transfer_size / transfer_kind / transfer_response / transfer_burst /
//     transfer_protection  - bus field encodings (HSIZE/HTRANS/HRESP/HBURST/HPROT)
//     slave_state          - subordinate FSM states
//     AHB_WORD_BYTES       - bytes per bus word
//     size_bytes()         - number of bytes moved by a transfer_size
// ---------------------------------------------------------------------------
package ahb_sram_slave_pkg;

    typedef enum logic [2:0] {
        SIZE_BYTE   = 3'd0,
        SIZE_HALF   = 3'd1,
        SIZE_WORD   = 3'd2,
        SIZE_DWORD  = 3'd3,
        SIZE_4WORD  = 3'd4,
        SIZE_8WORD  = 3'd5,
        SIZE_16WORD = 3'd6,
        SIZE_32WORD = 3'd7
    } transfer_size;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } transfer_kind;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } transfer_response;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } transfer_burst;

    // HPROT[3:0]; privileged=0 means a user-mode access.
    typedef struct packed {
        logic cacheable;
        logic bufferable;
        logic privileged;
        logic data_access;
    } transfer_protection;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state;

    localparam int unsigned AHB_WORD_BYTES = 4;

    function automatic logic [31:0] size_bytes(input transfer_size s);
        return 32'd1 << s;
    endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// ---------------------------------------------------------------------------
// ahb_byte_strobe
//   Combinational lane decoder for a 32-bit little-endian AHB data bus.
//   Ports:
//     size    in  transfer_size  transfer width
//     addr_lo in  2              byte address bits [1:0]
//     strobe  out 4              byte lanes touched (0 when bad)
//     bad     out 1              transfer wider than a word or misaligned
// ---------------------------------------------------------------------------
module ahb_byte_strobe
    import ahb_sram_slave_pkg::*;
(
    input  transfer_size size,
    input  logic [1:0]   addr_lo,
    output logic [3:0]   strobe,
    output logic         bad
);

    logic [31:0] nbytes;
    logic [31:0] nbytes_m1;
    logic [1:0]  align_mask;
    logic        oversize;
    logic        misaligned;

    assign nbytes     = size_bytes(size);
    assign nbytes_m1  = nbytes - 32'd1;
    // Low address bits that must be zero for a naturally aligned transfer.
    assign align_mask = nbytes_m1[1:0];
    assign oversize   = nbytes > AHB_WORD_BYTES;
    assign misaligned = |(addr_lo & align_mask);
    assign bad        = oversize || misaligned;

    // A lane is active when it lies in the same naturally aligned container
    // as the addressed byte, i.e. they agree on every non-alignment bit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign strobe[gi] = !bad && (((2'(gi) ^ addr_lo) & ~align_mask) == 2'b00);
        end
    endgenerate

endmodule

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//   AHB-Lite subordinate wrapping a word-organised on-chip SRAM.
//   Pipelined address/data phases, byte/halfword/word access, WAIT_STATES
//   wait cycles per legal data phase, two-cycle ERROR response for illegal
//   transfers (oversize, misaligned, out of range).
//
//   Optional feature macro: AHB_SRAM_WRITE_PROTECT_EN
//     Writes below RO_LIMIT, and user-mode (prot.privileged=0) accesses
//     below RO_LIMIT, get the ERROR response and leave memory unchanged.
//
//   Ports:
//     clock     in   system clock, rising edge
//     nreset    in   asynchronous active-low reset
//     sel       in   device select from the decoder
//     write     in   1=write, 0=read (address phase)
//     addr      in   byte address (address phase)
//     size      in   transfer width (address phase)
//     burst     in   ignored, each beat decoded on its own
//     prot      in   protection, used only with the optional feature
//     trans     in   IDLE/BUSY/NONSEQ/SEQ
//     ready_in  in   bus HREADY
//     wdata     in   write data (data phase)
//     rdata     out  read data, full word, holds between read completions
//     ready_out out  this device's HREADYOUT
//     resp      out  OKAY/ERROR
// ---------------------------------------------------------------------------
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RO_LIMIT    = 1024
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic               sel,
    input  logic               write,
    input  logic [31:0]        addr,
    input  transfer_size       size,
    input  transfer_burst      burst,
    input  transfer_protection prot,
    input  transfer_kind       trans,
    input  logic               ready_in,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready_out,
    output transfer_response   resp
);

    localparam int unsigned BYTES    = DEPTH_WORDS * AHB_WORD_BYTES;
    localparam int unsigned AW       = $clog2(BYTES);
    localparam int unsigned IW       = AW - 2;
    localparam logic [3:0]  WAIT_MAX = 4'(WAIT_STATES);

    slave_state    state_reg, state_next;
    logic          write_reg;
    logic [IW-1:0] word_idx_reg;
    logic [3:0]    strobe_reg;
    logic [3:0]    wait_cnt_reg;
    logic [31:0]   rdata_reg;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          slot_open;
    logic          take;
    logic          legal;
    logic          in_range;
    logic          prot_reject;
    logic          bus_bad;
    logic [3:0]    bus_strobe;
    logic          data_done;
    logic          commit;
    logic          load_from_bus;
    logic          load_late;
    logic          load_rd;
    logic [IW-1:0] rd_idx;
    logic          fwd_hit;
    logic [31:0]   fwd_mask;
    slave_state    accept_target;

    logic          unused_inputs;
    assign unused_inputs = ^{burst, prot};

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    ahb_byte_strobe u_strobe (
        .size    (size),
        .addr_lo (addr[1:0]),
        .strobe  (bus_strobe),
        .bad     (bus_bad)
    );

    assign accept   = sel && ready_in && (trans == TRANS_NONSEQ || trans == TRANS_SEQ);
    assign in_range = addr < 32'(BYTES);

`ifdef AHB_SRAM_WRITE_PROTECT_EN
    assign prot_reject = (addr < 32'(RO_LIMIT)) && (write || !prot.privileged);
`else
    assign prot_reject = 1'b0;
`endif

    assign legal = !bus_bad && in_range && !prot_reject;

    // A new address phase is only taken when the previous data phase is
    // ending (or there is none); ready_in already says so on a real bus,
    // but gating on our own state keeps a stray ready_in from corrupting
    // the transfer in flight.
    assign data_done = (wait_cnt_reg == WAIT_MAX);
    assign slot_open = (state_reg == ST_IDLE) || (state_reg == ST_ERR2) ||
                       (state_reg == ST_DATA && data_done);
    assign take      = accept && slot_open;

    assign accept_target = !accept ? ST_IDLE : (legal ? ST_DATA : ST_ERR1);

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = accept_target;
            ST_DATA: if (data_done) state_next = accept_target;
            ST_ERR1: state_next = ST_ERR2;
            ST_ERR2: state_next = accept_target;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_out = 1'b1;
        resp      = RESP_OKAY;
        case (state_reg)
            ST_DATA: ready_out = data_done;
            ST_ERR1: begin
                ready_out = 1'b0;
                resp      = RESP_ERROR;
            end
            ST_ERR2: resp = RESP_ERROR;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Address-phase capture and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            write_reg    <= 1'b0;
            word_idx_reg <= '0;
            strobe_reg   <= 4'b0000;
        end else if (take) begin
            write_reg    <= write;
            word_idx_reg <= addr[AW-1:2];
            strobe_reg   <= bus_strobe;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wait_cnt_reg <= 4'd0;
        end else if (take) begin
            wait_cnt_reg <= 4'd0;
        end else if (state_reg == ST_DATA && !data_done) begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // SRAM write: commits at the edge that ends a write data phase.
    // ------------------------------------------------------------------
    assign commit = (state_reg == ST_DATA) && data_done && write_reg;

    always_ff @(posedge clock) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe_reg[b]) begin
                    mem[word_idx_reg][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // SRAM read: the read is registered, so it is issued on the edge that
    // starts the completing cycle. With no wait states that is the accept
    // edge itself, taken straight from the bus address; otherwise it is
    // the edge before the final wait cycle ends.
    // ------------------------------------------------------------------
    assign load_from_bus = take && legal && !write && (WAIT_MAX == 4'd0);
    assign load_late     = (state_reg == ST_DATA) && !write_reg && !data_done &&
                           (wait_cnt_reg + 4'd1 == WAIT_MAX);
    assign load_rd       = load_from_bus || load_late;
    assign rd_idx        = load_from_bus ? addr[AW-1:2] : word_idx_reg;

    // A write to the same word may commit on the very edge the read is
    // issued (back-to-back write then read); its lanes are merged so the
    // read observes the write just as the bus ordering requires.
    assign fwd_hit = commit && (word_idx_reg == rd_idx);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
            assign fwd_mask[8*gi +: 8] = {8{fwd_hit && strobe_reg[gi]}};
        end
    endgenerate

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rdata_reg <= 32'd0;
        end else if (load_rd) begin
            rdata_reg <= (mem[rd_idx] & ~fwd_mask) | (wdata & fwd_mask);
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               nreset;
    logic               sel0, sel3, write;
    logic [31:0]        addr, wdata;
    transfer_size       size;
    transfer_burst      burst;
    transfer_protection prot;
    transfer_kind       trans;

    logic [31:0]      rdata0, rdata3;
    logic             ready0, ready3;
    transfer_response resp0, resp3;

    // Which instance the tasks talk to: 0 -> WAIT_STATES=0, 1 -> WAIT_STATES=3.
    logic             use3;
    logic [31:0]      rdata;
    logic             ready;
    transfer_response resp;
    assign rdata = use3 ? rdata3 : rdata0;
    assign ready = use3 ? ready3 : ready0;
    assign resp  = use3 ? resp3  : resp0;

    int n_checks = 0;
    int n_errors = 0;

    ahb_sram_slave #(.DEPTH_WORDS(512), .WAIT_STATES(0), .RO_LIMIT(1024)) dut0 (
        .clock(clock), .nreset(nreset), .sel(sel0), .write(write), .addr(addr),
        .size(size), .burst(burst), .prot(prot), .trans(trans), .ready_in(ready0),
        .wdata(wdata), .rdata(rdata0), .ready_out(ready0), .resp(resp0)
    );

    ahb_sram_slave #(.DEPTH_WORDS(512), .WAIT_STATES(3), .RO_LIMIT(1024)) dut3 (
        .clock(clock), .nreset(nreset), .sel(sel3), .write(write), .addr(addr),
        .size(size), .burst(burst), .prot(prot), .trans(trans), .ready_in(ready3),
        .wdata(wdata), .rdata(rdata3), .ready_out(ready3), .resp(resp3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic addr_phase(input logic w, input logic [31:0] a, input transfer_size s);
        sel0  = !use3;
        sel3  = use3;
        write = w;
        addr  = a;
        size  = s;
        trans = TRANS_NONSEQ;
    endtask

    task automatic bus_idle();
        sel0  = 1'b0;
        sel3  = 1'b0;
        trans = TRANS_IDLE;
    endtask

    task automatic wait_ready(input string tag, output int nwait);
        nwait = 0;
        while (ready !== 1'b1 && nwait < 40) begin
            nwait++;
            step();
        end
        if (nwait >= 40) check({tag, "_timeout"}, 32'(ready), 32'd1);
    endtask

    // One isolated transfer: address phase, then data phase until ready.
    task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                        input transfer_size s, input logic [31:0] d,
                        output logic [31:0] rd, output logic rdy1,
                        output transfer_response r1, output transfer_response rfin,
                        output int nwait);
        addr_phase(w, a, s);
        step();
        bus_idle();
        wdata = d;
        rdy1  = ready;
        r1    = resp;
        wait_ready(tag, nwait);
        rd    = rdata;
        rfin  = resp;
        $display("%-12s %s a=0x%08h size=%0d wait=%0d resp=%0d rdata=0x%08h",
                 tag, w ? "WR" : "RD", a, s, nwait, rfin, rd);
        step();
    endtask

    task automatic write_ok(input string tag, input logic [31:0] a, input transfer_size s,
                            input logic [31:0] d, input int exp_wait);
        logic [31:0] rd; logic rdy1; transfer_response r1, rfin; int nw;
        xfer(tag, 1'b1, a, s, d, rd, rdy1, r1, rfin, nw);
        check({tag, "_resp"}, 32'(rfin), 32'(RESP_OKAY));
        check({tag, "_wait"}, 32'(nw), 32'(exp_wait));
    endtask

    task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic rdy1; transfer_response r1, rfin; int nw;
        xfer(tag, 1'b0, a, SIZE_WORD, 32'd0, rd, rdy1, r1, rfin, nw);
        check({tag, "_resp"}, 32'(rfin), 32'(RESP_OKAY));
        check({tag, "_data"}, rd, exp);
    endtask

    task automatic read_word(input string tag, input logic [31:0] a, output logic [31:0] rd);
        logic rdy1; transfer_response r1, rfin; int nw;
        xfer(tag, 1'b0, a, SIZE_WORD, 32'd0, rd, rdy1, r1, rfin, nw);
        check({tag, "_resp"}, 32'(rfin), 32'(RESP_OKAY));
    endtask

    task automatic expect_error(input string tag, input logic w, input logic [31:0] a,
                                input transfer_size s, input logic [31:0] d,
                                input logic [31:0] exp_hold);
        logic [31:0] rd; logic rdy1; transfer_response r1, rfin; int nw;
        xfer(tag, w, a, s, d, rd, rdy1, r1, rfin, nw);
        check({tag, "_rdy1"},  32'(rdy1), 32'd0);
        check({tag, "_resp1"}, 32'(r1),   32'(RESP_ERROR));
        check({tag, "_resp2"}, 32'(rfin), 32'(RESP_ERROR));
        check({tag, "_len"},   32'(nw),   32'd1);
        check({tag, "_hold"},  rd,        exp_hold);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        logic [31:0] v;

        nreset = 1'b0;
        use3   = 1'b0;
        write  = 1'b0;
        addr   = 32'd0;
        wdata  = 32'd0;
        size   = SIZE_WORD;
        burst  = BURST_SINGLE;
        prot   = 4'b0011;
        bus_idle();

        // ---------------- reset state ----------------
        step(); step();
        check("rst_ready0", 32'(ready0), 32'd1);
        check("rst_resp0",  32'(resp0),  32'(RESP_OKAY));
        check("rst_rdata0", rdata0,      32'd0);
        check("rst_ready3", 32'(ready3), 32'd1);
        nreset = 1'b1;
        step();
        check("post_rst_ready0", 32'(ready0), 32'd1);

        // ---------------- back-to-back write then read, no wait states ----------------
        addr_phase(1'b1, 32'h10, SIZE_WORD);
        step();
        wdata = 32'hDEADBEEF;
        addr_phase(1'b0, 32'h10, SIZE_WORD);
        check("b2b_wr_ready", 32'(ready), 32'd1);
        step();
        bus_idle();
        check("b2b_rd_ready", 32'(ready), 32'd1);
        check("b2b_rd_resp",  32'(resp),  32'(RESP_OKAY));
        check("b2b_rd_data",  rdata,      32'hDEADBEEF);
        $display("b2b          WR/RD a=0x00000010 rdata=0x%08h", rdata);
        step();
        read_expect("rd_deadbeef", 32'h10, 32'hDEADBEEF);

        // ---------------- byte / halfword lanes ----------------
        write_ok("wr_clear", 32'h10, SIZE_WORD, 32'h00000000, 0);
        write_ok("wr_byte",  32'h11, SIZE_BYTE, 32'hFFFFAAFF, 0);
        read_expect("rd_byte", 32'h10, 32'h0000AA00);
        write_ok("wr_half",  32'h12, SIZE_HALF, 32'h1234FFFF, 0);
        read_expect("rd_half", 32'h10, 32'h1234AA00);
        write_ok("wr_b0",    32'h14, SIZE_WORD, 32'h00000000, 0);
        write_ok("wr_b3",    32'h17, SIZE_BYTE, 32'h5AFFFFFF, 0);
        write_ok("wr_h0",    32'h14, SIZE_HALF, 32'hFFFFC3C3, 0);
        read_expect("rd_lanes", 32'h14, 32'h5A00C3C3);
        read_expect("rd_half2", 32'h10, 32'h1234AA00);

        // ---------------- illegal transfers (rdata must hold) ----------------
        expect_error("err_rd_mis",  1'b0, 32'h2,   SIZE_WORD,  32'd0,        32'h1234AA00);
        expect_error("err_wr_mis",  1'b1, 32'h12,  SIZE_WORD,  32'hFFFFFFFF, 32'h1234AA00);
        expect_error("err_hw_mis",  1'b1, 32'h11,  SIZE_HALF,  32'hFFFFFFFF, 32'h1234AA00);
        expect_error("err_oor",     1'b0, 32'h800, SIZE_WORD,  32'd0,        32'h1234AA00);
        expect_error("err_dword",   1'b1, 32'h10,  SIZE_DWORD, 32'hFFFFFFFF, 32'h1234AA00);
        read_expect("rd_after_err", 32'h10, 32'h1234AA00);

        // last word of the array is legal
        write_ok("wr_top", 32'h7FC, SIZE_WORD, 32'h0BADF00D, 0);
        read_expect("rd_top", 32'h7FC, 32'h0BADF00D);

        // ---------------- no transfer: IDLE with sel, NONSEQ without sel ----------------
        sel0 = 1'b1; trans = TRANS_IDLE; write = 1'b1; addr = 32'h10; size = SIZE_WORD;
        step();
        wdata = 32'hFFFFFFFF;
        check("idle_sel_ready", 32'(ready), 32'd1);
        check("idle_sel_resp",  32'(resp),  32'(RESP_OKAY));
        step();
        sel0 = 1'b0; trans = TRANS_NONSEQ;
        step();
        check("nosel_ready", 32'(ready), 32'd1);
        check("nosel_resp",  32'(resp),  32'(RESP_OKAY));
        step();
        bus_idle();
        read_expect("rd_untouched", 32'h10, 32'h1234AA00);

        // ---------------- wait states: instance with WAIT_STATES=3 ----------------
        use3 = 1'b1;
        write_ok("w3_wr0", 32'h0, SIZE_WORD, 32'hA0A0A0A0, 3);
        write_ok("w3_wr4", 32'h4, SIZE_WORD, 32'hB4B4B4B4, 3);
        addr_phase(1'b0, 32'h0, SIZE_WORD);
        step();
        addr_phase(1'b0, 32'h4, SIZE_WORD);   // held until ready
        wait_ready("w3_rd0", nw);
        check("w3_rd0_wait", 32'(nw), 32'd3);
        check("w3_rd0_resp", 32'(resp), 32'(RESP_OKAY));
        check("w3_rd0_data", rdata, 32'hA0A0A0A0);
        $display("w3_rd0       RD a=0x00000000 wait=%0d rdata=0x%08h", nw, rdata);
        step();
        bus_idle();
        wait_ready("w3_rd4", nw);
        check("w3_rd4_wait", 32'(nw), 32'd3);
        check("w3_rd4_resp", 32'(resp), 32'(RESP_OKAY));
        check("w3_rd4_data", rdata, 32'hB4B4B4B4);
        $display("w3_rd4       RD a=0x00000004 wait=%0d rdata=0x%08h", nw, rdata);
        step();
        // error response ignores wait states
        expect_error("w3_err", 1'b0, 32'h802, SIZE_WORD, 32'd0, 32'hB4B4B4B4);

        // ---------------- reset in the middle of a write data phase ----------------
        write_ok("w3_wr20", 32'h20, SIZE_WORD, 32'h11111111, 3);
        addr_phase(1'b1, 32'h20, SIZE_WORD);
        step();
        bus_idle();
        wdata = 32'hCAFEF00D;
        check("mid_rst_busy", 32'(ready), 32'd0);
        #2;
        nreset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_resp",  32'(resp),  32'(RESP_OKAY));
        check("mid_rst_rdata", rdata,      32'd0);
        step(); step(); step(); step();
        nreset = 1'b1;
        step();
        read_expect("rd_after_rst", 32'h20, 32'h11111111);

        // ---------------- write protection ----------------
        use3 = 1'b0;
`ifdef AHB_SRAM_WRITE_PROTECT_EN
        read_word("wp_pre", 32'h100, v);
        expect_error("wp_wr_ro", 1'b1, 32'h100, SIZE_BYTE, 32'h00000055, v);
        read_expect("wp_rd_ro", 32'h100, v);
        write_ok("wp_wr_rw", 32'h400, SIZE_WORD, 32'h00000055, 0);
        read_expect("wp_rd_rw", 32'h400, 32'h00000055);
        prot = 4'b0001;   // user data access
        expect_error("wp_user_ro", 1'b0, 32'h100, SIZE_WORD, 32'd0, 32'h00000055);
        read_expect("wp_user_rw", 32'h400, 32'h00000055);
        prot = 4'b0011;
`else
        v = 32'd0;
        write_ok("np_wr_low", 32'h100, SIZE_BYTE, 32'h00000055, 0);
        write_ok("np_wr_b1",  32'h101, SIZE_BYTE, 32'h00000000, 0);
        write_ok("np_wr_h1",  32'h102, SIZE_HALF, 32'h00000000, 0);
        read_word("np_rd_low", 32'h100, v);
        check("np_rd_low_data", v, 32'h00000055);
        prot = 4'b0001;
        read_expect("np_user", 32'h100, 32'h00000055);
        prot = 4'b0011;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
